// File: rtl/cic_integrator_chain.sv
// Cascaded CIC integrator section for an I/Q sample pair: NUM_STAGES wrapping
// accumulators per rail, driven by a ready/valid handshake on both sides.
module cic_integrator_chain #(
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 32,
  parameter int NUM_STAGES = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic [IN_WIDTH-1:0]  i_inph_data,
  input  logic [IN_WIDTH-1:0]  i_quad_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [OUT_WIDTH-1:0] o_inph_data,
  output logic [OUT_WIDTH-1:0] o_quad_data,
  output logic                 o_valid,
  input  logic                 i_ready
);

  localparam int FILL_W = $clog2(NUM_STAGES + 1);
  localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(NUM_STAGES);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_STAGES - 1);

  logic [OUT_WIDTH-1:0] inph_acc [NUM_STAGES];
  logic [OUT_WIDTH-1:0] quad_acc [NUM_STAGES];
  logic [OUT_WIDTH-1:0] inph_ext;
  logic [OUT_WIDTH-1:0] quad_ext;
  logic [FILL_W-1:0]    fill_count;
  logic                 adv;

  assign inph_ext = OUT_WIDTH'($signed(i_inph_data));
  assign quad_ext = OUT_WIDTH'($signed(i_quad_data));

  assign o_ready = !o_valid || i_ready;
  assign adv     = i_valid && o_ready;

  assign o_inph_data = inph_acc[NUM_STAGES-1];
  assign o_quad_data = quad_acc[NUM_STAGES-1];

  // Reset and clear flush identical state, so they share one branch.
  always_ff @(posedge i_clock) begin
    if (i_reset || i_clear) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        inph_acc[k] <= '0;
        quad_acc[k] <= '0;
      end
      fill_count <= '0;
      o_valid    <= 1'b0;
    end else if (adv) begin
      inph_acc[0] <= inph_acc[0] + inph_ext;
      quad_acc[0] <= quad_acc[0] + quad_ext;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        inph_acc[k] <= inph_acc[k] + inph_acc[k-1];
        quad_acc[k] <= quad_acc[k] + quad_acc[k-1];
      end
      if (fill_count != FILL_MAX) begin
        fill_count <= fill_count + 1'b1;
      end
      if (fill_count >= FILL_LAST) begin
        o_valid <= 1'b1;
      end
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_integrator_chain.sv
// Self-checking bench for cic_integrator_chain: vector table, wrap case on a
// narrow instance, and randomized traffic against a cumulative-sum model.
module tb_cic_integrator_chain;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst, clr, iv, ir;
  logic [15:0] ii, iq;
  logic        o_ready, o_valid;
  logic [31:0] oi, oq;

  logic        w_rst, w_clr, w_iv, w_ir;
  logic [3:0]  w_ii, w_iq;
  logic        w_o_ready, w_o_valid;
  logic [5:0]  w_oi, w_oq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cic_integrator_chain #(.IN_WIDTH(16), .OUT_WIDTH(32), .NUM_STAGES(N)) dut (
    .i_clock(clk), .i_reset(rst), .i_clear(clr),
    .i_inph_data(ii), .i_quad_data(iq), .i_valid(iv), .o_ready(o_ready),
    .o_inph_data(oi), .o_quad_data(oq), .o_valid(o_valid), .i_ready(ir)
  );

  cic_integrator_chain #(.IN_WIDTH(4), .OUT_WIDTH(6), .NUM_STAGES(1)) dut_wrap (
    .i_clock(clk), .i_reset(w_rst), .i_clear(w_clr),
    .i_inph_data(w_ii), .i_quad_data(w_iq), .i_valid(w_iv), .o_ready(w_o_ready),
    .o_inph_data(w_oi), .o_quad_data(w_oq), .o_valid(w_o_valid), .i_ready(w_ir)
  );

  typedef struct {
    bit rst, clr, iv, ir;
    int ii, iq;
    bit ev;
    int ei, eq;
    bit cd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, c, v, rd, input int a, b, input bit ev, input int ei, eq, input bit cd);
    vec_t t;
    t = '{rst: r, clr: c, iv: v, ir: rd, ii: a, iq: b, ev: ev, ei: ei, eq: eq, cd: cd};
    vecs.push_back(t);
  endtask

  task automatic restart_seq();
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 1,1,-1,1);
    add(0,0,1,1,1,-1, 1,4,-4,1);
    add(0,0,1,1,1,-1, 1,10,-10,1);
    add(0,0,1,1,1,-1, 1,20,-20,1);
  endtask

  // N-fold running sum of the accepted samples; the last-stage output after
  // m accepts is the last element taken over the first m-N+1 samples.
  function automatic logic [31:0] nfold(input int xs[$], input int n);
    logic [31:0] a[$];
    int len;
    len = xs.size() - n + 1;
    if (len <= 0) return '0;
    for (int i = 0; i < len; i++) a.push_back(32'(xs[i]));
    repeat (n) for (int i = 1; i < len; i++) a[i] = a[i] + a[i-1];
    return a[len-1];
  endfunction

  initial begin
    int si[$];
    int sq[$];
    bit mvalid;
    bit adv_m;
    logic [5:0] wrap_exp [6];
    logic [15:0] ri, rq;

    rst = 1; clr = 0; iv = 0; ir = 1; ii = '0; iq = '0;
    w_rst = 1; w_clr = 0; w_iv = 0; w_ir = 1; w_ii = '0; w_iq = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(o_valid), 32'd0);
    chk("reset_ready", 32'(o_ready), 32'd1);
    chk("reset_inph", oi, 32'd0);
    chk("reset_quad", oq, 32'd0);

    // Impulse
    add(1,0,0,1,0,0, 0,0,0,1);
    add(0,0,1,1,1,0, 0,0,0,0);
    add(0,0,1,1,0,0, 0,0,0,0);
    add(0,0,1,1,0,0, 1,1,0,1);
    add(0,0,1,1,0,0, 1,3,0,1);
    add(0,0,1,1,0,0, 1,6,0,1);
    add(0,0,1,1,0,0, 1,10,0,1);
    add(0,0,1,1,0,0, 1,15,0,1);
    // Reset wins over a concurrent advance
    add(1,0,1,1,5,5, 0,0,0,1);
    // Step with backpressure after the second output
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 1,1,-1,1);
    add(0,0,1,1,1,-1, 1,4,-4,1);
    add(0,0,1,0,1,-1, 1,4,-4,1);
    add(0,0,1,0,1,-1, 1,4,-4,1);
    add(0,0,1,0,1,-1, 1,4,-4,1);
    add(0,0,1,1,1,-1, 1,10,-10,1);
    add(0,0,1,1,1,-1, 1,20,-20,1);
    // Clear concurrent with advance, then restart
    add(0,1,1,1,1,-1, 0,0,0,1);
    restart_seq();
    // Reset concurrent with advance, then restart
    add(1,0,1,1,1,-1, 0,0,0,1);
    restart_seq();
    // Bubbles
    add(1,0,0,1,0,0, 0,0,0,1);
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,0,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 0,0,0,0);
    add(0,0,0,1,1,-1, 0,0,0,0);
    add(0,0,1,1,1,-1, 1,1,-1,1);
    add(0,0,0,1,1,-1, 0,1,-1,1);
    add(0,0,1,1,1,-1, 1,4,-4,1);
    add(0,0,0,1,1,-1, 0,4,-4,1);
    add(0,0,1,1,1,-1, 1,10,-10,1);
    add(0,0,0,1,1,-1, 0,10,-10,1);
    add(0,0,1,1,1,-1, 1,20,-20,1);

    foreach (vecs[r]) begin
      rst = vecs[r].rst; clr = vecs[r].clr; iv = vecs[r].iv; ir = vecs[r].ir;
      ii = 16'(vecs[r].ii); iq = 16'(vecs[r].iq);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", r), 32'(o_valid), 32'(vecs[r].ev));
      chk($sformatf("vec%0d_ready", r), 32'(o_ready), 32'(!vecs[r].ev || vecs[r].ir));
      if (vecs[r].cd) begin
        chk($sformatf("vec%0d_inph", r), oi, 32'(vecs[r].ei));
        chk($sformatf("vec%0d_quad", r), oq, 32'(vecs[r].eq));
      end
    end

    // Wrap on a 6-bit single-stage instance
    wrap_exp = '{6'd7, 6'd14, 6'd21, 6'd28, 6'h23, 6'h2A};
    w_rst = 0; w_iv = 1; w_ii = 4'd7; w_iq = 4'd0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("wrap%0d_valid", k), 32'(w_o_valid), 32'd1);
      chk($sformatf("wrap%0d_inph", k), 32'(w_oi), 32'(wrap_exp[k]));
      chk($sformatf("wrap%0d_quad", k), 32'(w_oq), 32'd0);
    end
    w_iv = 0;

    // Randomized traffic
    rst = 1; clr = 0; iv = 0; ir = 1;
    @(posedge clk);
    @(negedge clk);
    mvalid = 0;
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(199) == 0);
      clr = ($urandom_range(99) == 0);
      iv  = ($urandom_range(3) != 0);
      ir  = ($urandom_range(2) != 0);
      ri  = 16'($urandom);
      rq  = 16'($urandom);
      ii  = ri; iq = rq;
      #1;
      chk("rand_ready", 32'(o_ready), 32'(!mvalid || ir));
      adv_m = iv && (!mvalid || ir);
      if (rst || clr) begin
        si.delete(); sq.delete(); mvalid = 0;
      end else if (adv_m) begin
        si.push_back(int'($signed(ri)));
        sq.push_back(int'($signed(rq)));
        if (si.size() >= N) mvalid = 1;
      end else if (mvalid && ir) begin
        mvalid = 0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("rand_valid", 32'(o_valid), 32'(mvalid));
      chk("rand_inph", oi, nfold(si, N));
      chk("rand_quad", oq, nfold(sq, N));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_integrator_chain.md
CIC_INTEGRATOR_CHAIN -- requirements
Module: cic_integrator_chain

Interface
REQ-001 Parameter IN_WIDTH, default 16: input sample width per rail, two's complement.
REQ-002 Parameter OUT_WIDTH, default 32: accumulator and output width per rail; SHALL satisfy OUT_WIDTH >= IN_WIDTH.
REQ-003 Parameter NUM_STAGES, default 4: number of cascaded integrator stages; SHALL satisfy NUM_STAGES >= 1.
REQ-004 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_clear  input  1  synchronous flush of all accumulators and fill state.
REQ-007 i_inph_data  input  IN_WIDTH  in-phase sample.
REQ-008 i_quad_data  input  IN_WIDTH  quadrature sample.
REQ-009 i_valid  input  1  input sample present.
REQ-010 o_ready  output  1  block accepts the input sample this cycle.
REQ-011 o_inph_data  output  OUT_WIDTH  in-phase output of the last stage.
REQ-012 o_quad_data  output  OUT_WIDTH  quadrature output of the last stage.
REQ-013 o_valid  output  1  output sample present.
REQ-014 i_ready  input  1  downstream accepts the output sample this cycle.

Function
REQ-015 o_ready SHALL equal (!o_valid || i_ready), combinationally.
REQ-016 Advance (adv) SHALL equal (i_valid && o_ready); all stage registers update only on adv.
REQ-017 On adv, stage 0 accumulator SHALL become acc0 + sign_extend(input) per rail.
REQ-018 On adv, stage k (k>=1) accumulator SHALL become acck + acc(k-1), using pre-edge values (one register per stage, fully pipelined).
REQ-019 All arithmetic SHALL be two's complement, wrapping modulo 2^OUT_WIDTH, with no saturation and no overflow flag.
REQ-020 I and Q rails SHALL be identical and independent and share one control path.
REQ-021 o_inph_data/o_quad_data SHALL be driven directly from the last-stage accumulators.
REQ-022 A fill counter SHALL count adv events, saturating at NUM_STAGES.
REQ-023 On adv with fill count >= NUM_STAGES-1 (pre-edge), o_valid SHALL be set to 1; first valid output follows the NUM_STAGES-th accepted sample.
REQ-024 On a cycle with o_valid && i_ready && !adv, o_valid SHALL clear to 0.
REQ-025 When o_valid && !i_ready, all accumulators, outputs and o_valid SHALL hold (backpressure stall, o_ready=0).
REQ-026 Latency: an input accepted on adv SHALL first affect the output after NUM_STAGES further adv-inclusive advances; each sample contributes to output at the NUM_STAGES-th adv counted from its own.
REQ-027 Throughput SHALL be one sample per cycle when i_valid and i_ready are held high.
REQ-028 i_clear SHALL zero all accumulators and the fill counter and clear o_valid; on i_clear && adv, clear SHALL win and the sample SHALL be dropped.

Reset
REQ-029 On i_reset: all accumulators 0, fill counter 0, o_valid 0, o_inph_data 0, o_quad_data 0; i_reset SHALL take priority over i_clear and adv.
REQ-030 After reset, o_ready SHALL be 1 (o_valid=0).
REQ-031 Reset asserted mid-stream SHALL discard all in-flight state; the next output follows NUM_STAGES fresh samples.

Verification
REQ-032 Impulse, N=3: I=1 then I=0, i_valid/i_ready held high -> o_valid outputs I = 1, 3, 6, 10, 15; Q = 0.
REQ-033 Step, N=3: I=1 and Q=-1 every cycle -> I outputs 1, 4, 10, 20; Q outputs -1, -4, -10, -20.
REQ-034 Wrap, N=1, IN_WIDTH=4, OUT_WIDTH=6: I=7 every cycle -> outputs 7, 14, 21, 28, then 6'h23 (35 mod 64).
REQ-035 Backpressure, N=3, step input: drop i_ready for 3 cycles after the second output -> o_ready=0, output held at 4, sequence resumes 10, 20 with no loss or duplication.
REQ-036 Bubbles: i_valid toggled 1/0 with step input -> output values identical to REQ-033, o_valid on alternating cycles.
REQ-037 Clear/reset: assert i_clear concurrently with adv mid-stream -> o_valid=0 next cycle, sample dropped, restart yields REQ-033 sequence; repeat with i_reset -> same result.
